// File: rtl/ball_game_pkg.sv
// Shared types and constants for the ball game controller.
//   state_t    : controller FSM encoding (visible on ctrl_state)
//   *_DEF      : default screen / ball geometry
//   centre_pos : left/top edge that centres the ball on an axis
//   clamp10    : clamp a 10-bit value into [lo, hi]
package ball_game_pkg;

  localparam int H_ACTIVE_DEF  = 640;
  localparam int V_ACTIVE_DEF  = 480;
  localparam int BALL_SIZE_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_MOVE     = 3'd2,
    ST_ARMED    = 3'd3,
    ST_COOLDOWN = 3'd4,
    ST_MISS     = 3'd5
  } state_t;

  function automatic int centre_pos(input int active, input int size);
    return (active - size) / 2;
  endfunction

  localparam int CENTRE_X = centre_pos(H_ACTIVE_DEF, BALL_SIZE_DEF);
  localparam int CENTRE_Y = centre_pos(V_ACTIVE_DEF, BALL_SIZE_DEF);

  function automatic logic [9:0] clamp10(input logic [9:0] v,
                                         input logic [9:0] lo,
                                         input logic [9:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/hit_window_gen.sv
// Combinational hit-window test for the current pixel.
//   en          : window allowed this cycle
//   ball_x/y    : ball top-left corner
//   x/y_pixel   : pixel being scanned
//   is_hit_area : pixel lies in the ball box grown by HIT_MARGIN on every side
module hit_window_gen #(
  parameter int BALL_SIZE  = 16,
  parameter int HIT_MARGIN = 8
) (
  input  logic       en,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] x_pixel,
  input  logic [9:0] y_pixel,
  output logic       is_hit_area
);

  // Signed 11-bit so the lower bound near the screen edge goes negative
  // instead of wrapping to a large value.
  localparam logic signed [10:0] LO_OFF = 11'(HIT_MARGIN);
  localparam logic signed [10:0] HI_OFF = 11'(BALL_SIZE + HIT_MARGIN);

  logic signed [10:0] bx, by, px, py;
  logic in_x, in_y;

  always_comb begin
    bx   = $signed({1'b0, ball_x});
    by   = $signed({1'b0, ball_y});
    px   = $signed({1'b0, x_pixel});
    py   = $signed({1'b0, y_pixel});
    in_x = (px >= bx - LO_OFF) && (px < bx + HI_OFF);
    in_y = (py >= by - LO_OFF) && (py < by + HI_OFF);
    is_hit_area = en && in_x && in_y;
  end

endmodule

// File: rtl/ball_game_controller.sv
// Per-frame sequencer for the ball hit-detection datapath.
// Owns ball position / speed / direction, arms the collision detector's
// hit window when the ball approaches the left side, bounces the ball on a
// reported collision and scores hits and misses.
//   clk_25MHz, reset_n        : pixel clock, async active-low reset
//   game_enable               : level, 0 forces IDLE
//   frame_start               : one pulse per frame, advances the ball
//   x_pixel, y_pixel          : current scan position
//   collision_detected,
//   estimated_speed           : detector result, valid together
//   is_hit_area               : combinational window flag for current pixel
//   is_ball_moving_left       : direction flag to detector
//   ball_x, ball_y, ball_speed: ball state
//   ctrl_state                : FSM state
//   miss_pulse                : one cycle per miss
//   hit_count, miss_count     : saturating scores
module ball_game_controller
  import ball_game_pkg::*;
#(
  parameter int H_ACTIVE        = H_ACTIVE_DEF,
  parameter int V_ACTIVE        = V_ACTIVE_DEF,
  parameter int BALL_SIZE       = BALL_SIZE_DEF,
  parameter int HIT_MARGIN      = 8,
  parameter int ZONE_X          = 160,
  parameter int INIT_SPEED      = 4,
  parameter int MIN_SPEED       = 2,
  parameter int MAX_SPEED       = 12,
  parameter int Y_STEP          = 2,
  parameter int SERVE_FRAMES    = 60,
  parameter int COOLDOWN_FRAMES = 10
) (
  input  logic       clk_25MHz,
  input  logic       reset_n,
  input  logic       game_enable,
  input  logic       frame_start,
  input  logic [9:0] x_pixel,
  input  logic [9:0] y_pixel,
  input  logic       collision_detected,
  input  logic [9:0] estimated_speed,
  output logic       is_hit_area,
  output logic       is_ball_moving_left,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] ball_speed,
  output logic [2:0] ctrl_state,
  output logic       miss_pulse,
  output logic [7:0] hit_count,
  output logic [7:0] miss_count
);

  localparam logic [9:0]  CX      = 10'(centre_pos(H_ACTIVE, BALL_SIZE));
  localparam logic [9:0]  CY      = 10'(centre_pos(V_ACTIVE, BALL_SIZE));
  localparam logic [10:0] X_LIM   = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] Y_LIM   = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0]  X_MAX   = 10'(H_ACTIVE - BALL_SIZE);
  localparam logic [9:0]  Y_MAX   = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0]  YSTEP   = 10'(Y_STEP);
  localparam logic [9:0]  ZONE    = 10'(ZONE_X);
  localparam logic [9:0]  SPD0    = 10'(INIT_SPEED);
  localparam logic [9:0]  SPD_MIN = 10'(MIN_SPEED);
  localparam logic [9:0]  SPD_MAX = 10'(MAX_SPEED);
  localparam int          FCW     = $clog2((SERVE_FRAMES > COOLDOWN_FRAMES ?
                                            SERVE_FRAMES : COOLDOWN_FRAMES) + 1);
  localparam logic [FCW-1:0] SERVE_LAST = FCW'(SERVE_FRAMES - 1);
  localparam logic [FCW-1:0] COOL_LAST  = FCW'(COOLDOWN_FRAMES - 1);

  state_t           state, state_d;
  logic [9:0]       x_q, x_d, y_q, y_d, spd_q, spd_d;
  logic             left_q, left_d, down_q, down_d;
  logic [7:0]       hits_q, hits_d, miss_q, miss_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic             pulse_q, pulse_d;

  // Candidate per-frame motion. A hit in ARMED reverses and re-speeds the
  // ball before the same-cycle frame update, so motion uses the new values.
  logic             hit_now;
  logic [9:0]       spd_hit, mv_spd, mv_x, mv_y;
  logic             mv_dir_left, mv_left, mv_down;
  logic [10:0]      x_fwd, y_fwd;

  always_comb begin
    hit_now     = (state == ST_ARMED) && collision_detected;
    spd_hit     = clamp10(estimated_speed, SPD_MIN, SPD_MAX);
    mv_spd      = hit_now ? spd_hit : spd_q;
    mv_dir_left = hit_now ? 1'b0 : left_q;
    x_fwd       = {1'b0, x_q} + {1'b0, mv_spd};
    y_fwd       = {1'b0, y_q} + {1'b0, YSTEP};

    mv_left = mv_dir_left;
    if (mv_dir_left)          mv_x = x_q - mv_spd;
    else if (x_fwd >= X_LIM) begin
      mv_x    = X_MAX;
      mv_left = 1'b1;
    end else                  mv_x = x_fwd[9:0];

    mv_down = down_q;
    if (down_q) begin
      if (y_fwd >= Y_LIM) begin
        mv_y    = Y_MAX;
        mv_down = 1'b0;
      end else mv_y = y_fwd[9:0];
    end else if (y_q <= YSTEP) begin
      mv_y    = '0;
      mv_down = 1'b1;
    end else mv_y = y_q - YSTEP;
  end

  always_comb begin
    state_d = state;
    x_d     = x_q;
    y_d     = y_q;
    spd_d   = spd_q;
    left_d  = left_q;
    down_d  = down_q;
    hits_d  = hits_q;
    miss_d  = miss_q;
    fcnt_d  = fcnt_q;
    pulse_d = 1'b0;

    if (!game_enable) begin
      state_d = ST_IDLE;
      x_d     = CX;
      y_d     = CY;
      spd_d   = SPD0;
      left_d  = 1'b1;
      fcnt_d  = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          x_d     = CX;
          y_d     = CY;
          spd_d   = SPD0;
          left_d  = 1'b1;
          fcnt_d  = '0;
          state_d = ST_SERVE;
        end
        ST_SERVE: if (frame_start) begin
          if (fcnt_q == SERVE_LAST) begin
            fcnt_d  = '0;
            state_d = ST_MOVE;
          end else fcnt_d = fcnt_q + 1'b1;
        end
        ST_MOVE: begin
          if (frame_start) begin
            x_d = mv_x; y_d = mv_y; left_d = mv_left; down_d = mv_down;
          end
          if (left_q && x_q <= ZONE) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (hit_now) begin
            spd_d   = spd_hit;
            left_d  = 1'b0;
            hits_d  = (hits_q == 8'hFF) ? hits_q : hits_q + 8'd1;
            fcnt_d  = '0;
            state_d = ST_COOLDOWN;
            if (frame_start) begin
              x_d = mv_x; y_d = mv_y; left_d = mv_left; down_d = mv_down;
            end
          end else if (frame_start) begin
            y_d = mv_y; down_d = mv_down;
            if (x_q <= spd_q) begin
              x_d     = '0;
              state_d = ST_MISS;
            end else begin
              x_d = mv_x; left_d = mv_left;
            end
          end
        end
        ST_COOLDOWN: if (frame_start) begin
          x_d = mv_x; y_d = mv_y; left_d = mv_left; down_d = mv_down;
          if (fcnt_q == COOL_LAST) begin
            fcnt_d  = '0;
            state_d = ST_MOVE;
          end else fcnt_d = fcnt_q + 1'b1;
        end
        ST_MISS: begin
          pulse_d = 1'b1;
          miss_d  = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;
          x_d     = CX;
          y_d     = CY;
          spd_d   = SPD0;
          left_d  = 1'b1;
          fcnt_d  = '0;
          state_d = ST_SERVE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      x_q     <= CX;
      y_q     <= CY;
      spd_q   <= SPD0;
      left_q  <= 1'b1;
      down_q  <= 1'b1;
      hits_q  <= '0;
      miss_q  <= '0;
      fcnt_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state   <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      spd_q   <= spd_d;
      left_q  <= left_d;
      down_q  <= down_d;
      hits_q  <= hits_d;
      miss_q  <= miss_d;
      fcnt_q  <= fcnt_d;
      pulse_q <= pulse_d;
    end
  end

  hit_window_gen #(
    .BALL_SIZE (BALL_SIZE),
    .HIT_MARGIN(HIT_MARGIN)
  ) u_hit_window (
    .en         (state == ST_ARMED),
    .ball_x     (x_q),
    .ball_y     (y_q),
    .x_pixel    (x_pixel),
    .y_pixel    (y_pixel),
    .is_hit_area(is_hit_area)
  );

  assign is_ball_moving_left = left_q;
  assign ball_x              = x_q;
  assign ball_y              = y_q;
  assign ball_speed          = spd_q;
  assign ctrl_state          = state;
  assign miss_pulse          = pulse_q;
  assign hit_count           = hits_q;
  assign miss_count          = miss_q;

endmodule

// File: tb/tb_ball_game_controller.sv
// Bench for ball_game_controller: a game-level reference model predicts
// every output each cycle into a queue; a negedge monitor pops and compares.
// Directed sequences walk the serve / arm / hit / miss / wall / disable
// paths, then randomized play runs against the same model.
module tb_ball_game_controller;

  localparam int S_IDLE = 0, S_SERVE = 1, S_MOVE = 2, S_ARMED = 3,
                 S_COOL = 4, S_MISS = 5;

  logic       clk_25MHz = 1'b0;
  logic       reset_n;
  logic       game_enable, frame_start, collision_detected;
  logic [9:0] x_pixel, y_pixel, estimated_speed;
  logic       is_hit_area, is_ball_moving_left, miss_pulse;
  logic [9:0] ball_x, ball_y, ball_speed;
  logic [2:0] ctrl_state;
  logic [7:0] hit_count, miss_count;

  always #20 clk_25MHz = ~clk_25MHz;

  ball_game_controller dut (
    .clk_25MHz          (clk_25MHz),
    .reset_n            (reset_n),
    .game_enable        (game_enable),
    .frame_start        (frame_start),
    .x_pixel            (x_pixel),
    .y_pixel            (y_pixel),
    .collision_detected (collision_detected),
    .estimated_speed    (estimated_speed),
    .is_hit_area        (is_hit_area),
    .is_ball_moving_left(is_ball_moving_left),
    .ball_x             (ball_x),
    .ball_y             (ball_y),
    .ball_speed         (ball_speed),
    .ctrl_state         (ctrl_state),
    .miss_pulse         (miss_pulse),
    .hit_count          (hit_count),
    .miss_count         (miss_count)
  );

  typedef struct {
    int st, x, y, spd, left, hits, miss, pulse, hit;
  } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;

  // ---------------- reference model (game rules, plain integers) ----------
  int m_st, mx, my, mspd, mleft, mdown, mhits, mmiss, mcnt, mpulse;

  function void centre();
    mx = 312; my = 232; mspd = 4; mleft = 1;
  endfunction

  function void model_reset();
    m_st = S_IDLE; centre(); mdown = 1;
    mhits = 0; mmiss = 0; mcnt = 0; mpulse = 0;
  endfunction

  function void fly_h();
    if (mleft) mx = mx - mspd;
    else if (mx + mspd >= 624) begin mx = 624; mleft = 1; end
    else mx = mx + mspd;
  endfunction

  function void fly_v();
    if (mdown) begin
      if (my + 2 >= 464) begin my = 464; mdown = 0; end
      else my = my + 2;
    end else begin
      if (my <= 2) begin my = 0; mdown = 1; end
      else my = my - 2;
    end
  endfunction

  function int model_hit(int px, int py);
    if (m_st != S_ARMED) return 0;
    return int'(px >= mx - 8 && px < mx + 24 && py >= my - 8 && py < my + 24);
  endfunction

  function void model_step(int en, int fs, int col, int est);
    bit armed_now;
    mpulse = int'(en != 0 && m_st == S_MISS);
    if (en == 0) begin
      m_st = S_IDLE; centre();
      return;
    end
    case (m_st)
      S_IDLE: begin centre(); mcnt = 0; m_st = S_SERVE; end
      S_SERVE: if (fs != 0) begin
        mcnt++;
        if (mcnt == 60) begin mcnt = 0; m_st = S_MOVE; end
      end
      S_MOVE: begin
        armed_now = (mleft != 0) && (mx <= 160);
        if (fs != 0) begin fly_h(); fly_v(); end
        if (armed_now) m_st = S_ARMED;
      end
      S_ARMED: begin
        if (col != 0) begin
          mleft = 0;
          mspd  = (est < 2) ? 2 : (est > 12) ? 12 : est;
          if (mhits < 255) mhits++;
          mcnt = 0; m_st = S_COOL;
          if (fs != 0) begin fly_h(); fly_v(); end
        end else if (fs != 0) begin
          if (mx <= mspd) begin mx = 0; fly_v(); m_st = S_MISS; end
          else begin fly_h(); fly_v(); end
        end
      end
      S_COOL: if (fs != 0) begin
        fly_h(); fly_v();
        mcnt++;
        if (mcnt == 10) begin mcnt = 0; m_st = S_MOVE; end
      end
      S_MISS: begin
        if (mmiss < 255) mmiss++;
        centre(); mcnt = 0; m_st = S_SERVE;
      end
      default: m_st = S_IDLE;
    endcase
  endfunction

  // ---------------- checking -----------------------------------------------
  function void chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endfunction

  function void timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s: loop bound expired", name);
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_25MHz);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_state", int'(ctrl_state),          e.st);
        chk("sb_x",     int'(ball_x),              e.x);
        chk("sb_y",     int'(ball_y),              e.y);
        chk("sb_speed", int'(ball_speed),          e.spd);
        chk("sb_left",  int'(is_ball_moving_left), e.left);
        chk("sb_hits",  int'(hit_count),           e.hits);
        chk("sb_miss",  int'(miss_count),          e.miss);
        chk("sb_pulse", int'(miss_pulse),          e.pulse);
        chk("sb_hit",   int'(is_hit_area),         e.hit);
      end
    end
  end

  // ---------------- stimulus -----------------------------------------------
  task automatic tick(input int e, input int f, input int c, input int es,
                      input int px, input int py);
    exp_t x;
    int pxm, pym;
    @(posedge clk_25MHz); #1;
    pxm = px & 1023;
    pym = py & 1023;
    game_enable        = (e != 0);
    frame_start        = (f != 0);
    collision_detected = (c != 0);
    estimated_speed    = 10'(es);
    x_pixel            = 10'(pxm);
    y_pixel            = 10'(pym);
    x = '{st: m_st, x: mx, y: my, spd: mspd, left: mleft, hits: mhits,
          miss: mmiss, pulse: mpulse, hit: model_hit(pxm, pym)};
    q.push_back(x);
    model_step(e, f, c, es);
  endtask

  function int near(int c);
    if ($urandom_range(0, 3) != 0) return c - 12 + int'($urandom_range(0, 40));
    return int'($urandom_range(0, 1023));
  endfunction

  task automatic idle(); tick(1, 0, 0, 0, near(mx), near(my)); endtask

  task automatic frame();
    tick(1, 1, 0, 0, near(mx), near(my));
    idle(); idle();
  endtask

  // Apply one more idle cycle and sample the outputs it exposes.
  task automatic settle();
    idle();
    @(negedge clk_25MHz); #1;
  endtask

  task automatic probe(string name, int dx, int dy, int expv);
    tick(1, 0, 0, 0, mx + dx, my + dy);
    @(negedge clk_25MHz); #1;
    chk(name, int'(is_hit_area), expv);
  endtask

  task automatic do_reset();
    @(negedge clk_25MHz); #2;
    reset_n = 1'b0;
    game_enable = 0; frame_start = 0; collision_detected = 0;
    estimated_speed = 0; x_pixel = 0; y_pixel = 0;
    #1;
    chk("rst_state", int'(ctrl_state), 0);
    chk("rst_x", int'(ball_x), 312);
    chk("rst_y", int'(ball_y), 232);
    chk("rst_speed", int'(ball_speed), 4);
    chk("rst_left", int'(is_ball_moving_left), 1);
    chk("rst_hits", int'(hit_count), 0);
    chk("rst_miss", int'(miss_count), 0);
    chk("rst_pulse", int'(miss_pulse), 0);
    chk("rst_hit", int'(is_hit_area), 0);
    model_reset();
    #3;
    reset_n = 1'b1;
  endtask

  initial begin : driver
    int n, pre_x;
    bit found;
    reset_n = 1'b0;
    game_enable = 0; frame_start = 0; collision_detected = 0;
    estimated_speed = 0; x_pixel = 0; y_pixel = 0;
    model_reset();
    repeat (3) @(posedge clk_25MHz);
    do_reset();

    // Serve: 60 frames, then first move step.
    idle();
    repeat (59) frame();
    @(negedge clk_25MHz); #1;
    chk("serve_59", int'(ctrl_state), 1);
    frame();
    @(negedge clk_25MHz); #1;
    chk("serve_done", int'(ctrl_state), 2);
    chk("serve_x", int'(ball_x), 312);
    frame();
    @(negedge clk_25MHz); #1;
    chk("move1_x", int'(ball_x), 308);
    chk("move1_y", int'(ball_y), 234);

    // Window disabled outside ARMED.
    probe("move_win_tl", -8, -8, 0);
    probe("move_win_br", 23, 23, 0);

    // Approach until armed at x=100.
    n = 0;
    while (!(m_st == S_ARMED && mx == 100) && n < 300) begin frame(); n++; end
    if (n >= 300) timeout("reach_x100");
    @(negedge clk_25MHz); #1;
    chk("armed_state", int'(ctrl_state), 3);
    chk("armed_x", int'(ball_x), 100);
    probe("win_tl",      -8, -8, 1);
    probe("win_br",      23, 23, 1);
    probe("win_left_out", -9, -8, 0);
    probe("win_right_out", 24, 8, 0);
    probe("win_below_out", 0, 24, 0);

    // Hit with oversize speed estimate.
    tick(1, 0, 1, 20, 0, 0);
    settle();
    chk("hit1_left", int'(is_ball_moving_left), 0);
    chk("hit1_speed", int'(ball_speed), 12);
    chk("hit1_count", int'(hit_count), 1);
    chk("hit1_state", int'(ctrl_state), 4);

    n = 0;
    while (m_st != S_ARMED && n < 400) begin frame(); n++; end
    if (n >= 400) timeout("rearm1");

    // Hit with zero estimate, then cooldown length.
    tick(1, 0, 1, 0, 0, 0);
    settle();
    chk("hit2_speed", int'(ball_speed), 2);
    chk("hit2_count", int'(hit_count), 2);
    repeat (9) frame();
    @(negedge clk_25MHz); #1;
    chk("cool_9", int'(ctrl_state), 4);
    frame();
    @(negedge clk_25MHz); #1;
    chk("cool_10", int'(ctrl_state), 2);

    // Slow return, then let it miss.
    n = 0;
    while (m_st != S_ARMED && n < 1000) begin frame(); n++; end
    if (n >= 1000) timeout("rearm2");
    found = 0; n = 0;
    while (!found && n < 300) begin
      tick(1, 1, 0, 0, near(mx), near(my));
      if (m_st == S_MISS) begin
        found = 1;
        settle();
        chk("miss_state", int'(ctrl_state), 5);
        chk("miss_x", int'(ball_x), 0);
        chk("miss_pulse_pre", int'(miss_pulse), 0);
        settle();
        chk("miss_pulse_hi", int'(miss_pulse), 1);
        chk("miss_count", int'(miss_count), 1);
        chk("miss_serve", int'(ctrl_state), 1);
        chk("miss_recentre", int'(ball_x), 312);
        settle();
        chk("miss_pulse_lo", int'(miss_pulse), 0);
      end else begin
        idle(); idle();
      end
      n++;
    end
    if (!found) timeout("miss");

    // Serve again; simultaneous hit + frame near the left edge.
    repeat (61) frame();
    n = 0;
    while (!(m_st == S_ARMED && mx == 8) && n < 300) begin frame(); n++; end
    if (n >= 300) timeout("reach_x8");
    pre_x = mx;
    tick(1, 1, 1, 6, 0, 0);
    settle();
    chk("simul_x", int'(ball_x), pre_x + 6);
    chk("simul_left", int'(is_ball_moving_left), 0);
    chk("simul_state", int'(ctrl_state), 4);
    chk("simul_speed", int'(ball_speed), 6);

    // Right wall clamp.
    n = 0;
    while (!(mx == 620 && mleft == 0) && n < 400) begin frame(); n++; end
    if (n >= 400) timeout("reach_x620");
    frame();
    @(negedge clk_25MHz); #1;
    chk("wall_x", int'(ball_x), 624);
    chk("wall_left", int'(is_ball_moving_left), 1);

    // Disable while armed.
    n = 0;
    while (m_st != S_ARMED && n < 400) begin frame(); n++; end
    if (n >= 400) timeout("rearm3");
    tick(0, 0, 0, 0, mx, my);
    tick(0, 0, 0, 0, 312, 232);
    @(negedge clk_25MHz); #1;
    chk("dis_state", int'(ctrl_state), 0);
    chk("dis_hit", int'(is_hit_area), 0);
    chk("dis_x", int'(ball_x), 312);
    chk("dis_hits", int'(hit_count), 3);
    chk("dis_miss", int'(miss_count), 1);

    // Randomized play.
    for (int i = 0; i < 6000; i++) begin
      tick(($urandom_range(0, 1999) != 0) ? 1 : 0,
           ($urandom_range(0, 1) == 0) ? 1 : 0,
           ($urandom_range(0, 7) == 0) ? 1 : 0,
           int'($urandom_range(0, 31)),
           near(mx), near(my));
    end

    // Reset in the middle of play.
    do_reset();
    repeat (4) idle();
    @(negedge clk_25MHz); #1;
    chk("queue_drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
